alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle combinational ALU in the MIPS datapath.
- Executes single-cycle logic/arithmetic ops in one clock.
- Executes shifts and multiply iteratively over several clocks, so the EX stage can stall on in_ready/out_valid instead of building a barrel shifter and array multiplier.
- Sits between the ID/EX register and EX/MEM register; the stall logic watches in_ready and out_valid.

Parameters:
- WIDTH, 32: operand and result width in bits; must be a power of 2, minimum 8.
- SHW, $clog2(WIDTH): shift-amount width, derived; not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands and op presented
- in_ready  output  1  block can accept an op this cycle
- in1  input  WIDTH  operand A
- in2  input  WIDTH  operand B; shifts use in2[SHW-1:0] as the amount
- aluop  input  4  operation code, see Behaviour
- out_valid  output  1  result registered and held
- out_ready  input  1  consumer takes the result this cycle
- outRes  output  WIDTH  result
- zeroflag  output  1  outRes == 0
- eqflag  output  1  in1 == in2, captured at accept
- ovflag  output  1  signed overflow; see Optional Feature

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset values:
  - state = IDLE
  - out_valid = 0
  - outRes = 0
  - zeroflag, eqflag, ovflag = 0
  - in_ready = 0 while reset is high
- Reset mid-operation aborts any iteration and discards the pending result.
- Accept: an op is accepted when in_valid & in_ready. Operands and aluop are latched at accept; later changes on the inputs are ignored.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Back-to-back acceptance in the same cycle the previous result is consumed is therefore allowed.
- Opcodes:
  - 0 add
  - 1 sub
  - 2 bitwise and
  - 3 bitwise or
  - 4 slt (signed, result 0 or 1)
  - 5 nor
  - 6 sll
  - 7 srl
  - 8 sra
  - 9 sltu (unsigned, result 0 or 1)
  - 10 xor
  - 11 mul (low WIDTH bits of the product)
  - 12-15: reserved; result 0, latency 1
- Arithmetic is modulo 2^WIDTH; carry out is discarded.
- State machine:
  - IDLE --accept, single-cycle op--> DONE
  - IDLE --accept, shift or mul--> BUSY
  - BUSY --counter expires--> DONE
  - DONE --out_ready & !in_valid--> IDLE
  - DONE --out_ready & in_valid--> DONE or BUSY, accepting the next op
- Latency (accept edge to out_valid high):
  - single-cycle ops: 1
  - shifts: max(1, shamt); the iterator shifts one bit per cycle
  - mul: WIDTH; shift-add, one multiplier bit per cycle
- Shift amount 0 yields outRes = in1 with latency 1.
- sra replicates in1[WIDTH-1].
- out_valid and all result outputs stay stable from assertion until the cycle out_ready is high. No result is ever dropped or overwritten while out_valid=1 and out_ready=0.
- zeroflag is computed from the final result and registered with outRes.
- in_valid while BUSY is ignored, since in_ready=0.

Optional Feature:
- Macro: ALU_SEQ_OVF_EN.
- Defined: ovflag = signed overflow for add/sub (operand signs equal and differ from the result sign for add; operand signs differ and result sign differs from in1 for sub). ovflag = 0 for all other ops. Registered with outRes.
- Not defined: ovflag is tied to 0. The port remains so the instantiation is unchanged.

Decomposition:
- Package alu_seq_pkg:
  - 4-bit op enum (OP_ADD ... OP_MUL)
  - state enum (IDLE, BUSY, DONE)
  - constant OP_LAST_VALID = 11
- Sub-module alu_seq_iter: iterative shift/multiply engine. Interface: start, op, a, b, done, result. Includes the bit counter and accumulator.
- The top holds the FSM, handshake, single-cycle datapath and flag registers.

Test Plan (WIDTH=32):
- Reset held 2 cycles mid-mul -> out_valid=0, outRes=0, in_ready=1 first cycle after reset drops.
- add 5+5, out_ready=1 -> out_valid one cycle after accept, outRes=10, eqflag=1, zeroflag=0. Then sub 7-7 accepted in the consume cycle -> outRes=0, zeroflag=1.
- sra 0x80000000 by 4 -> outRes=0xF8000000 after exactly 4 cycles; in_ready=0 throughout BUSY. sll by 0 -> outRes=in1 in 1 cycle.
- mul 0xFFFF x 0x10001 -> outRes=0xFFFFFFFF after 32 cycles; in_valid pulses during BUSY are ignored.
- out_ready held 0 for 5 cycles after slt(-1,1) -> outRes=1 stable, out_valid=1 held; new in_valid not accepted until out_ready=1.
- With ALU_SEQ_OVF_EN: add 0x7FFFFFFF+1 -> ovflag=1, outRes=0x80000000. Without the macro -> ovflag=0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcode and state encodings for the handshaked sequential ALU.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SLT  = 4'd4,
    OP_NOR  = 4'd5,
    OP_SLL  = 4'd6,
    OP_SRL  = 4'd7,
    OP_SRA  = 4'd8,
    OP_SLTU = 4'd9,
    OP_XOR  = 4'd10,
    OP_MUL  = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] OP_LAST_VALID = 4'd11;

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative engine: one shift bit or one multiplier bit per clock.
// The first step is taken in the start cycle; done flags the cycle whose step is the last.
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  logic [3:0]       op_p0;
  logic [WIDTH-1:0] acc_p0;
  logic [WIDTH-1:0] mcand_p0;
  logic [WIDTH-1:0] mplier_p0;
  logic [SHW-1:0]   cnt_p0;
  logic [WIDTH-1:0] acc_next;

  function automatic logic [WIDTH-1:0] shift1(input logic [3:0] sop, input logic [WIDTH-1:0] x);
    case (sop)
      OP_SLL:  return {x[WIDTH-2:0], 1'b0};
      OP_SRL:  return {1'b0, x[WIDTH-1:1]};
      OP_SRA:  return {x[WIDTH-1], x[WIDTH-1:1]};
      default: return x;
    endcase
  endfunction

  always_comb begin
    acc_next = shift1(op_p0, acc_p0);
    if (op_p0 == OP_MUL)
      acc_next = acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);
  end

  assign done   = (cnt_p0 == SHW'(1));
  assign result = acc_next;

  always_ff @(posedge clk) begin
    if (reset)
      cnt_p0 <= '0;
    else if (start)
      cnt_p0 <= (op == OP_MUL) ? SHW'(WIDTH - 1) : b[SHW-1:0] - SHW'(1);
    else if (cnt_p0 != '0)
      cnt_p0 <= cnt_p0 - SHW'(1);
  end

  // Step 0 happens at start: multiplier bit 0 or the first shift position.
  always_ff @(posedge clk) begin
    if (start) begin
      op_p0     <= op;
      acc_p0    <= (op == OP_MUL) ? (b[0] ? a : '0) : shift1(op, a);
      mcand_p0  <= {a[WIDTH-2:0], 1'b0};
      mplier_p0 <= {1'b0, b[WIDTH-1:1]};
    end else begin
      acc_p0    <= acc_next;
      mcand_p0  <= {mcand_p0[WIDTH-2:0], 1'b0};
      mplier_p0 <= {1'b0, mplier_p0[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops in one clock, shifts/mul iterated in alu_seq_iter.
// Optional macro ALU_SEQ_OVF_EN enables the signed-overflow flag for add/sub.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       aluop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] outRes,
  output logic             zeroflag,
  output logic             eqflag,
  output logic             ovflag
);

  state_e           state;
  logic             accept;
  logic             multi;
  logic             iter_start;
  logic             iter_done;
  logic [WIDTH-1:0] iter_result;
  logic [WIDTH-1:0] res_p0;
  logic             ov_p0;
  logic [SHW-1:0]   shamt;

  function automatic logic [WIDTH-1:0] single_op(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [SHW-1:0] sh);
    logic signed [WIDTH-1:0] as;
    logic signed [WIDTH-1:0] bs;
    as = a;
    bs = b;
    if (op > OP_LAST_VALID) return '0;
    // Shifts only reach here with an amount of 0 or 1.
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_SLT:  return {{(WIDTH-1){1'b0}}, as < bs};
      OP_NOR:  return ~(a | b);
      OP_SLL:  return (sh == '0) ? a : {a[WIDTH-2:0], 1'b0};
      OP_SRL:  return (sh == '0) ? a : {1'b0, a[WIDTH-1:1]};
      OP_SRA:  return (sh == '0) ? a : {a[WIDTH-1], a[WIDTH-1:1]};
      OP_SLTU: return {{(WIDTH-1){1'b0}}, a < b};
      OP_XOR:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  function automatic logic overflow(input logic [3:0] op,
                                    input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b,
                                    input logic [WIDTH-1:0] r);
`ifdef ALU_SEQ_OVF_EN
    case (op)
      OP_ADD:  return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      OP_SUB:  return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      default: return 1'b0;
    endcase
`else
    return 1'b0 & (op[0] ^ a[0] ^ b[0] ^ r[0]);
`endif
  endfunction

  assign in_ready   = !reset && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept     = in_valid && in_ready;
  assign iter_start = accept && multi;

  always_comb begin
    shamt  = in2[SHW-1:0];
    multi  = (aluop == OP_MUL) ||
             (((aluop == OP_SLL) || (aluop == OP_SRL) || (aluop == OP_SRA)) && (shamt > SHW'(1)));
    res_p0 = single_op(aluop, in1, in2, shamt);
    ov_p0  = overflow(aluop, in1, in2, res_p0);
  end

  alu_seq_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (iter_start),
    .op     (aluop),
    .a      (in1),
    .b      (in2),
    .done   (iter_done),
    .result (iter_result)
  );

  // Result registers change only at accept or when the iteration finishes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      outRes    <= '0;
      zeroflag  <= 1'b0;
      eqflag    <= 1'b0;
      ovflag    <= 1'b0;
    end else begin
      case (state)
        BUSY: begin
          if (iter_done) begin
            state     <= DONE;
            out_valid <= 1'b1;
            outRes    <= iter_result;
            zeroflag  <= (iter_result == '0);
            ovflag    <= 1'b0;
          end
        end
        default: begin
          if (accept) begin
            eqflag <= (in1 == in2);
            if (multi) begin
              state     <= BUSY;
              out_valid <= 1'b0;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              outRes    <= res_p0;
              zeroflag  <= (res_p0 == '0);
              ovflag    <= ov_p0;
            end
          end else if ((state == DONE) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
